// File: rtl/compas_nios2_gen2_0_cpu_debug_cmd_sync_if.sv
// Signal bundle between the TCK-domain JTAG debug slave / OCI units and the
// clk-domain command receiver.
interface compas_nios2_gen2_0_cpu_debug_cmd_sync_if #(
   parameter int SR_W = 38,
   parameter int IR_W = 2
);
   logic            vs_udr;
   logic            vs_uir;
   logic [IR_W-1:0] ir_in;
   logic [SR_W-1:0] sr;
   logic            hold;

   logic [SR_W-1:0] jdo;
   logic            take_action_ocimem_a;
   logic            take_action_ocimem_b;
   logic            take_no_action_ocimem_a;
   logic            take_action_break_a;
   logic            take_action_break_b;
   logic            take_action_break_c;
   logic            take_no_action_break_a;
   logic            take_no_action_break_b;
   logic            take_no_action_break_c;
   logic            take_action_tracectrl;
   logic            cmd_pending;
   logic            overrun;
   logic [7:0]      cmd_count;

   modport master (
      output vs_udr, vs_uir, ir_in, sr, hold,
      input  jdo,
      input  take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
      input  take_action_break_a, take_action_break_b, take_action_break_c,
      input  take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
      input  take_action_tracectrl,
      input  cmd_pending, overrun, cmd_count
   );

   modport slave (
      input  vs_udr, vs_uir, ir_in, sr, hold,
      output jdo,
      output take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
      output take_action_break_a, take_action_break_b, take_action_break_c,
      output take_no_action_break_a, take_no_action_break_b, take_no_action_break_c,
      output take_action_tracectrl,
      output cmd_pending, overrun, cmd_count
   );
endinterface

// File: rtl/compas_nios2_gen2_0_cpu_debug_cmd_sync.sv
// Clock-domain receiver for JTAG debug commands: synchronises the TCK update strobes,
// captures the shift register and issues one-cycle OCI command strobes.
module compas_nios2_gen2_0_cpu_debug_cmd_sync #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2
) (
   input logic clk,
   input logic reset,
   compas_nios2_gen2_0_cpu_debug_cmd_sync_if.slave dbg
);

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   typedef struct packed {
      logic oci_a;
      logic oci_b;
      logic no_oci_a;
      logic brk_a;
      logic brk_b;
      logic brk_c;
      logic no_brk_a;
      logic no_brk_b;
      logic no_brk_c;
      logic trc;
   } strobe_t;

   state_t state;
   state_t state_next;

   logic [SYNC_STAGES-1:0] udr_sync;
   logic [SYNC_STAGES-1:0] uir_sync;
   logic                   udr_prev;
   logic                   uir_prev;
   logic                   udr_rise;
   logic                   uir_rise;

   logic [IR_W-1:0] ir_q;
   logic [IR_W-1:0] ir_cmd;
   logic [SR_W-1:0] jdo_q;
   logic [7:0]      count_q;
   logic            overrun_q;

   logic            capture;
   logic            issue;
   logic            pending;

   strobe_t strobe_d;
   strobe_t strobe_q;

   // The TCK-domain levels are only trusted after the synchroniser chain; the
   // edge flop turns each level change into a single-cycle rising-edge event.
   always_ff @(posedge clk) begin
      if (reset) begin
         udr_sync <= '0;
         uir_sync <= '0;
         udr_prev <= 1'b0;
         uir_prev <= 1'b0;
      end else begin
         udr_sync <= {udr_sync[SYNC_STAGES-2:0], dbg.vs_udr};
         uir_sync <= {uir_sync[SYNC_STAGES-2:0], dbg.vs_uir};
         udr_prev <= udr_sync[SYNC_STAGES-1];
         uir_prev <= uir_sync[SYNC_STAGES-1];
      end
   end

   assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev;
   assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (udr_rise)  state_next = PENDING;
         PENDING: if (!dbg.hold) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      capture = 1'b0;
      issue   = 1'b0;
      pending = 1'b0;
      case (state)
         IDLE: begin
            capture = udr_rise;
         end
         PENDING: begin
            pending = 1'b1;
            issue   = ~dbg.hold;
         end
         default: ;
      endcase
   end

   // The command latches the IR that was current before this edge, so a
   // simultaneous IR update only affects the following command.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_q   <= '0;
         ir_cmd <= '0;
         jdo_q  <= '0;
      end else begin
         if (capture) begin
            jdo_q  <= dbg.sr;
            ir_cmd <= ir_q;
         end
         if (uir_rise) begin
            ir_q <= dbg.ir_in;
         end
      end
   end

   // A DR update arriving while one is still pending is lost; flag it sticky.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         if (udr_rise && pending) begin
            overrun_q <= 1'b1;
         end
         if (issue) begin
            count_q <= count_q + 8'd1;
         end
      end
   end

   always_comb begin
      strobe_d = '0;
      if (issue) begin
         case (ir_cmd)
            IR_W'(0): begin
               if (jdo_q[35])      strobe_d.oci_b    = 1'b1;
               else if (jdo_q[34]) strobe_d.oci_a    = 1'b1;
               else                strobe_d.no_oci_a = 1'b1;
            end
            IR_W'(2): begin
               if (jdo_q[37]) begin
                  if (!jdo_q[36])     strobe_d.brk_a = 1'b1;
                  else if (!jdo_q[35]) strobe_d.brk_b = 1'b1;
                  else                strobe_d.brk_c = 1'b1;
               end else begin
                  if (!jdo_q[36])     strobe_d.no_brk_a = 1'b1;
                  else if (!jdo_q[35]) strobe_d.no_brk_b = 1'b1;
                  else                strobe_d.no_brk_c = 1'b1;
               end
            end
            IR_W'(3): begin
               strobe_d.trc = jdo_q[15];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_q <= '0;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign dbg.jdo                    = jdo_q;
   assign dbg.take_action_ocimem_a    = strobe_q.oci_a;
   assign dbg.take_action_ocimem_b    = strobe_q.oci_b;
   assign dbg.take_no_action_ocimem_a = strobe_q.no_oci_a;
   assign dbg.take_action_break_a     = strobe_q.brk_a;
   assign dbg.take_action_break_b     = strobe_q.brk_b;
   assign dbg.take_action_break_c     = strobe_q.brk_c;
   assign dbg.take_no_action_break_a  = strobe_q.no_brk_a;
   assign dbg.take_no_action_break_b  = strobe_q.no_brk_b;
   assign dbg.take_no_action_break_c  = strobe_q.no_brk_c;
   assign dbg.take_action_tracectrl   = strobe_q.trc;
   assign dbg.cmd_pending             = pending;
   assign dbg.overrun                 = overrun_q;
   assign dbg.cmd_count               = count_q;

endmodule

// File: tb/tb_compas_nios2_gen2_0_cpu_debug_cmd_sync.sv
// Randomised and directed bench for the debug command receiver, checked every cycle
// against an event-level reference model.
module tb_compas_nios2_gen2_0_cpu_debug_cmd_sync;

   localparam int SR_W = 38;
   localparam int IR_W = 2;
   localparam int SYNC = 2;

   localparam int B_OCI_A  = 0;
   localparam int B_OCI_B  = 1;
   localparam int B_NOCI_A = 2;
   localparam int B_BRK_A  = 3;
   localparam int B_NBRK_A = 6;
   localparam int B_TRC    = 9;

   logic clk;
   logic reset;

   compas_nios2_gen2_0_cpu_debug_cmd_sync_if #(.SR_W(SR_W), .IR_W(IR_W)) dbg_if ();

   compas_nios2_gen2_0_cpu_debug_cmd_sync #(
      .SR_W(SR_W),
      .IR_W(IR_W),
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .dbg(dbg_if)
   );

   int check_count = 0;
   int error_count = 0;
   int pulse_cnt [10];
   int total_pulses = 0;

   logic [9:0] dut_strobes;
   assign dut_strobes = {dbg_if.take_action_tracectrl,
                         dbg_if.take_no_action_break_c, dbg_if.take_no_action_break_b,
                         dbg_if.take_no_action_break_a,
                         dbg_if.take_action_break_c, dbg_if.take_action_break_b,
                         dbg_if.take_action_break_a,
                         dbg_if.take_no_action_ocimem_a, dbg_if.take_action_ocimem_b,
                         dbg_if.take_action_ocimem_a};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Reference model: works on sampled level histories and command events.
   logic            model_valid = 1'b0;
   logic [SR_W-1:0] m_jdo;
   logic [IR_W-1:0] m_irq;
   logic [IR_W-1:0] m_ircmd;
   logic            m_pending;
   logic            m_overrun;
   logic [7:0]      m_count;
   logic [9:0]      m_strobe;
   logic            udr_h[$];
   logic            uir_h[$];

   function automatic logic [9:0] expectStrobe(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] j);
      logic [9:0] r;
      int         which;
      r = '0;
      which = (!j[36]) ? 0 : ((!j[35]) ? 1 : 2);
      case (ir)
         2'd0: r[j[35] ? B_OCI_B : (j[34] ? B_OCI_A : B_NOCI_A)] = 1'b1;
         2'd2: r[(j[37] ? B_BRK_A : B_NBRK_A) + which] = 1'b1;
         2'd3: r[B_TRC] = j[15];
         default: ;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin : model_blk
      logic old_p;
      logic udr_ev;
      logic uir_ev;
      if (reset) begin
         model_valid = 1'b1;
         m_jdo = '0; m_irq = '0; m_ircmd = '0;
         m_pending = 1'b0; m_overrun = 1'b0; m_count = '0; m_strobe = '0;
         udr_h = {};
         uir_h = {};
         for (int i = 0; i <= SYNC; i++) begin
            udr_h.push_back(1'b0);
            uir_h.push_back(1'b0);
         end
      end else if (model_valid) begin
         udr_h.push_back(dbg_if.vs_udr);
         uir_h.push_back(dbg_if.vs_uir);
         udr_ev = udr_h[udr_h.size()-1-SYNC] && !udr_h[udr_h.size()-2-SYNC];
         uir_ev = uir_h[uir_h.size()-1-SYNC] && !uir_h[uir_h.size()-2-SYNC];
         old_p = m_pending;
         m_strobe = '0;
         if (old_p && !dbg_if.hold) begin
            m_strobe  = expectStrobe(m_ircmd, m_jdo);
            m_pending = 1'b0;
            m_count   = m_count + 8'd1;
         end
         if (udr_ev) begin
            if (old_p) begin
               m_overrun = 1'b1;
            end else begin
               m_jdo     = dbg_if.sr;
               m_ircmd   = m_irq;
               m_pending = 1'b1;
            end
         end
         if (uir_ev) m_irq = dbg_if.ir_in;
         while (udr_h.size() > 16) begin
            void'(udr_h.pop_front());
            void'(uir_h.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("strobes", 64'(dut_strobes), 64'(m_strobe));
         checkOutput("jdo", 64'(dbg_if.jdo), 64'(m_jdo));
         checkOutput("cmd_pending", 64'(dbg_if.cmd_pending), 64'(m_pending));
         checkOutput("overrun", 64'(dbg_if.overrun), 64'(m_overrun));
         checkOutput("cmd_count", 64'(dbg_if.cmd_count), 64'(m_count));
         for (int i = 0; i < 10; i++) begin
            if (dut_strobes[i] === 1'b1) begin
               pulse_cnt[i]++;
               total_pulses++;
            end
         end
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic udr, input logic uir, input logic [SR_W-1:0] sr_v,
                                input logic [IR_W-1:0] ir_v, input int high_cycles,
                                input int low_cycles);
      dbg_if.sr    = sr_v;
      dbg_if.ir_in = ir_v;
      waitCycles(1);
      dbg_if.vs_udr = udr;
      dbg_if.vs_uir = uir;
      waitCycles(high_cycles);
      dbg_if.vs_udr = 1'b0;
      dbg_if.vs_uir = 1'b0;
      waitCycles(low_cycles);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int base;
      int base2;
      logic [SR_W-1:0] sr_a;
      logic [SR_W-1:0] sr_b;

      for (int i = 0; i < 10; i++) pulse_cnt[i] = 0;
      reset = 1'b1;
      dbg_if.vs_udr = 1'b0;
      dbg_if.vs_uir = 1'b0;
      dbg_if.ir_in  = '0;
      dbg_if.sr     = '0;
      dbg_if.hold   = 1'b0;
      waitCycles(3);
      checkOutput("rst_count", 64'(dbg_if.cmd_count), 64'd0);
      checkOutput("rst_pending", 64'(dbg_if.cmd_pending), 64'd0);
      checkOutput("rst_jdo", 64'(dbg_if.jdo), 64'd0);
      checkOutput("rst_strobes", 64'(dut_strobes), 64'd0);
      reset = 1'b0;
      waitCycles(2);

      // Break command: strobe exactly at E+2.
      applyStimulus(1'b0, 1'b1, '0, 2'd2, 3, 4);
      dbg_if.sr = {4'b1000, 34'h0};
      waitCycles(1);
      dbg_if.vs_udr = 1'b1;
      waitCycles(3);
      checkOutput("t1_pending_e1", 64'(dbg_if.cmd_pending), 64'd1);
      checkOutput("t1_break_a_e1", 64'(dbg_if.take_action_break_a), 64'd0);
      waitCycles(1);
      checkOutput("t1_break_a_e2", 64'(dbg_if.take_action_break_a), 64'd1);
      checkOutput("t1_jdo_hi", 64'(dbg_if.jdo[37:34]), 64'h8);
      checkOutput("t1_count", 64'(dbg_if.cmd_count), 64'd1);
      waitCycles(1);
      checkOutput("t1_break_a_e3", 64'(dbg_if.take_action_break_a), 64'd0);
      dbg_if.vs_udr = 1'b0;
      waitCycles(4);

      // Hold defers issue.
      applyStimulus(1'b0, 1'b1, '0, 2'd0, 3, 4);
      dbg_if.hold = 1'b1;
      applyStimulus(1'b1, 1'b0, 38'h04_0000_0000, 2'd0, 3, 10);
      checkOutput("t2_pending_held", 64'(dbg_if.cmd_pending), 64'd1);
      checkOutput("t2_ocimem_a_held", 64'(pulse_cnt[B_OCI_A]), 64'd0);
      dbg_if.hold = 1'b0;
      waitCycles(4);
      checkOutput("t2_ocimem_a", 64'(pulse_cnt[B_OCI_A]), 64'd1);
      checkOutput("t2_pending_clr", 64'(dbg_if.cmd_pending), 64'd0);
      checkOutput("t2_count", 64'(dbg_if.cmd_count), 64'd2);

      // Overrun: second update lost while held.
      sr_a = 38'h08_0000_0000;
      sr_b = 38'h04_0000_0000;
      base = total_pulses;
      dbg_if.hold = 1'b1;
      applyStimulus(1'b1, 1'b0, sr_a, 2'd0, 3, 5);
      applyStimulus(1'b1, 1'b0, sr_b, 2'd0, 3, 5);
      checkOutput("t3_overrun", 64'(dbg_if.overrun), 64'd1);
      checkOutput("t3_jdo_first", 64'(dbg_if.jdo), 64'(sr_a));
      dbg_if.hold = 1'b0;
      waitCycles(5);
      checkOutput("t3_one_strobe", 64'(total_pulses - base), 64'd1);
      checkOutput("t3_ocimem_b", 64'(pulse_cnt[B_OCI_B]), 64'd1);

      // Same-cycle IR and DR updates: old IR used, new IR for the next command.
      base  = pulse_cnt[B_NOCI_A];
      base2 = pulse_cnt[B_TRC];
      applyStimulus(1'b1, 1'b1, 38'h8000, 2'd3, 3, 6);
      checkOutput("t4_old_ir", 64'(pulse_cnt[B_NOCI_A] - base), 64'd1);
      checkOutput("t4_no_trc_yet", 64'(pulse_cnt[B_TRC] - base2), 64'd0);
      applyStimulus(1'b1, 1'b0, 38'h8000, 2'd3, 3, 6);
      checkOutput("t4_trc", 64'(pulse_cnt[B_TRC] - base2), 64'd1);

      // Reset discards a pending command.
      dbg_if.hold = 1'b1;
      applyStimulus(1'b1, 1'b0, 38'h3F_FFFF_FFFF, 2'd3, 3, 4);
      checkOutput("t5_pending_before", 64'(dbg_if.cmd_pending), 64'd1);
      base = total_pulses;
      reset = 1'b1;
      waitCycles(1);
      checkOutput("t5_pending", 64'(dbg_if.cmd_pending), 64'd0);
      checkOutput("t5_overrun", 64'(dbg_if.overrun), 64'd0);
      checkOutput("t5_count", 64'(dbg_if.cmd_count), 64'd0);
      checkOutput("t5_jdo", 64'(dbg_if.jdo), 64'd0);
      reset = 1'b0;
      dbg_if.hold = 1'b0;
      waitCycles(6);
      checkOutput("t5_no_strobe", 64'(total_pulses - base), 64'd0);

      // 256 silent commands wrap the counter.
      applyStimulus(1'b0, 1'b1, '0, 2'd1, 3, 4);
      base = total_pulses;
      for (int n = 1; n <= 256; n++) begin
         applyStimulus(1'b1, 1'b0, 38'(n * 32'h0123_4567), 2'd1, 3, 4);
         if (n == 255) checkOutput("t6_count_255", 64'(dbg_if.cmd_count), 64'd255);
      end
      checkOutput("t6_count_wrap", 64'(dbg_if.cmd_count), 64'd0);
      checkOutput("t6_no_strobes", 64'(total_pulses - base), 64'd0);

      // Random mix of IR/DR updates, hold and occasional reset.
      for (int it = 0; it < 400; it++) begin
         int sel;
         logic [SR_W-1:0] rsr;
         rsr = 38'({$urandom(), $urandom()});
         sel = int'($urandom_range(0, 99));
         dbg_if.hold = ($urandom_range(0, 3) == 0);
         if (sel < 2) begin
            reset = 1'b1;
            waitCycles(1);
            reset = 1'b0;
         end else if (sel < 55) begin
            applyStimulus(1'b1, 1'b0, rsr, 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
         end else if (sel < 85) begin
            applyStimulus(1'b0, 1'b1, rsr, 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
         end else begin
            applyStimulus(1'b1, 1'b1, rsr, 2'($urandom_range(0, 3)),
                          int'($urandom_range(1, 4)), int'($urandom_range(1, 6)));
         end
      end
      dbg_if.hold = 1'b0;
      waitCycles(8);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
